// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file's single write port.
// Latency: accept -> slot (1 edge) -> output register (1 edge); a requester stalls only while its slot is full and ungranted.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [AW-1:0]     req0_addr,
  input  logic [DW-1:0]     req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AW-1:0]     req1_addr,
  input  logic [DW-1:0]     req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd,
  output logic              grant_id,
  output logic [2**AW-1:0]  busy
);

  localparam int NR = 2**AW;

  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  slot_t         slot [2];
  logic          older;   // 1 when slot 1 holds the earlier write
  logic          rr;      // last requester granted
  logic          gnt_vld;
  logic          gnt_sel;
  logic [1:0]    grant;
  logic [1:0]    ready;
  logic [1:0]    req_valid;
  logic [1:0]    hs;
  logic [1:0]    fill;
  logic [1:0]    stay;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  always_comb begin
    gnt_vld = slot[0].full | slot[1].full;
    if (slot[0].full && slot[1].full)
      gnt_sel = (slot[0].addr == slot[1].addr) ? older : ~rr;
    else
      gnt_sel = slot[1].full;
    grant[0] = gnt_vld & ~gnt_sel;
    grant[1] = gnt_vld & gnt_sel;
  end

  // Ready never looks at valid, so no combinational path from valid back to ready.
  assign ready      = ~{slot[1].full, slot[0].full} | grant;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign hs         = req_valid & ready;
  assign fill[0]    = hs[0] & (req_addr[0] != '0);
  assign fill[1]    = hs[1] & (req_addr[1] != '0);
  assign stay[0]    = slot[0].full & ~grant[0];
  assign stay[1]    = slot[1].full & ~grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        slot[k].full <= 1'b0;
        slot[k].addr <= '0;
        slot[k].data <= '0;
      end
      older    <= 1'b0;
      rr       <= 1'b1;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (hs[k]) begin
          slot[k].full <= fill[k];
          slot[k].addr <= req_addr[k];
          slot[k].data <= req_data[k];
        end else if (grant[k]) begin
          slot[k].full <= 1'b0;
        end
      end
      if (fill[0] && fill[1])
        older <= 1'b0;
      else if (fill[1] && stay[0])
        older <= 1'b0;
      else if (fill[0] && stay[1])
        older <= 1'b1;
      if (gnt_vld) begin
        rf_we    <= 1'b1;
        rf_wa    <= slot[gnt_sel].addr;
        rf_wd    <= slot[gnt_sel].data;
        grant_id <= gnt_sel;
        rr       <= gnt_sel;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  // Register 0 is excluded even though a slot never captures it.
  always_comb begin
    busy = '0;
    for (int a = 1; a < NR; a++)
      busy[a] = (slot[0].full && slot[0].addr == AW'(a)) ||
                (slot[1].full && slot[1].addr == AW'(a));
  end

endmodule
